// File: rtl/ieee_fp_pkg.sv
// Shared types and constants for the single-precision divider.
// FSM state encoding plus IEEE-754 field widths, bias and canonical quiet NaN.
package ieee_fp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        NORM,
        DONE
    } state_t;

    localparam int          BIAS   = 127;
    localparam logic [31:0] QNAN   = 32'h7FC0_0000;
    localparam int          EXP_W  = 8;
    localparam int          FRAC_W = 23;

    function automatic logic [31:0] signed_inf(input logic sgn);
        return {sgn, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    endfunction

    function automatic logic [31:0] signed_zero(input logic sgn);
        return {sgn, 31'd0};
    endfunction

endpackage

// File: rtl/restoring_div_step.sv
// One restoring radix-2 step: trial-subtract the divisor, keep the difference when non-negative.
// Purely combinational; the caller shifts the remainder.
module restoring_div_step #(
    parameter int W = 26
) (
    input  logic [W-1:0] remainder,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] new_remainder,
    output logic         quotient_bit
);

    logic [W:0] diff;

    always_comb begin
        diff          = {1'b0, remainder} - {1'b0, divisor};
        quotient_bit  = ~diff[W];
        new_remainder = quotient_bit ? diff[W-1:0] : remainder;
    end

endmodule

// File: rtl/ieee_divider.sv
// Iterative IEEE-754 single-precision divider, truncating, denormals flushed to zero.
// Specials resolve at the accepting edge; normal operands take QBITS divide cycles plus one normalise cycle.
module ieee_divider
    import ieee_fp_pkg::*;
#(
    parameter int QBITS = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] number1,
    input  logic [31:0] number2,
    input  logic        start,
    output logic [31:0] result,
    output logic        ready,
    output logic        busy
);

    localparam int RW = FRAC_W + 3;

    state_t             state, next_state;
    logic [4:0]         cnt;
    logic [QBITS-1:0]   quot;
    logic [RW-1:0]      rem;
    logic [RW-1:0]      dvsr;
    logic signed [9:0]  exp_q;
    logic               sign_q;

    logic [EXP_W-1:0]   a_exp, b_exp;
    logic [FRAC_W-1:0]  a_frac, b_frac;
    logic               a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic               in_sign;
    logic               spec_hit;
    logic [31:0]        spec_res;

    logic [RW-1:0]      step_rem;
    logic               step_bit;

    logic [QBITS-1:0]   quot_norm;
    logic signed [9:0]  exp_norm;
    logic [31:0]        norm_res;

    assign a_exp   = number1[30:23];
    assign a_frac  = number1[22:0];
    assign b_exp   = number2[30:23];
    assign b_frac  = number2[22:0];
    assign in_sign = number1[31] ^ number2[31];

    // Exponent 0 covers both true zero and denormals, which are flushed.
    always_comb begin
        a_zero   = (a_exp == '0);
        b_zero   = (b_exp == '0);
        a_inf    = (a_exp == '1) && (a_frac == '0);
        b_inf    = (b_exp == '1) && (b_frac == '0);
        a_nan    = (a_exp == '1) && (a_frac != '0);
        b_nan    = (b_exp == '1) && (b_frac != '0);
        spec_hit = 1'b1;
        spec_res = QNAN;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_res = QNAN;
        end else if (b_zero || a_inf) begin
            spec_res = signed_inf(in_sign);
        end else if (a_zero || b_inf) begin
            spec_res = signed_zero(in_sign);
        end else begin
            spec_hit = 1'b0;
        end
    end

    restoring_div_step #(.W(RW)) u_step (
        .remainder     (rem),
        .divisor       (dvsr),
        .new_remainder (step_rem),
        .quotient_bit  (step_bit)
    );

    // Quotient lies in (0.5, 2): at most one left shift brings the leading one to the MSB.
    always_comb begin
        quot_norm = quot;
        exp_norm  = exp_q;
        if (!quot[QBITS-1]) begin
            quot_norm = quot << 1;
            exp_norm  = exp_q - 10'sd1;
        end
        if (exp_norm >= 10'sd255) begin
            norm_res = signed_inf(sign_q);
        end else if (exp_norm <= 10'sd0) begin
            norm_res = signed_zero(sign_q);
        end else begin
            norm_res = {sign_q, exp_norm[EXP_W-1:0], quot_norm[QBITS-2 -: FRAC_W]};
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = spec_hit ? DONE : DIV;
            DIV:  if (cnt == 5'(QBITS - 1)) next_state = NORM;
            NORM: next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            result <= '0;
            cnt    <= '0;
            quot   <= '0;
            rem    <= '0;
            dvsr   <= '0;
            exp_q  <= '0;
            sign_q <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_q <= in_sign;
                        exp_q  <= $signed({2'b00, a_exp}) - $signed({2'b00, b_exp})
                                  + $signed(10'(BIAS));
                        rem    <= {2'b00, 1'b1, a_frac};
                        dvsr   <= {2'b00, 1'b1, b_frac};
                        quot   <= '0;
                        cnt    <= '0;
                        if (spec_hit) result <= spec_res;
                    end
                end
                DIV: begin
                    rem  <= step_rem << 1;
                    quot <= {quot[QBITS-2:0], step_bit};
                    cnt  <= (cnt == 5'(QBITS - 1)) ? 5'd0 : cnt + 5'd1;
                end
                NORM: begin
                    quot   <= quot_norm;
                    exp_q  <= exp_norm;
                    result <= norm_res;
                end
                default: ;
            endcase
        end
    end

    assign ready = (state == DONE);
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_ieee_divider.sv
// Directed-vector bench for ieee_divider: driver pushes expected result/latency/busy-run,
// a negedge monitor pops and compares on every ready pulse.
module tb_ieee_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] number1 = '0;
    logic [31:0] number2 = '0;
    logic        start = 1'b0;
    logic [31:0] result;
    logic        ready;
    logic        busy;

    ieee_divider dut (
        .clk     (clk),
        .rst     (rst),
        .number1 (number1),
        .number2 (number2),
        .start   (start),
        .result  (result),
        .ready   (ready),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          start_cyc;
        int          lat;
        int          busy_run;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Monitor
    exp_t        cur;
    int          run = 0;
    logic        prev_ready = 1'b0;
    logic        last_valid = 1'b0;
    logic [31:0] last_res = '0;

    always @(negedge clk) begin
        if (rst) begin
            run        = 0;
            last_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (ready) begin
                check("ready_single_cycle", {31'd0, prev_ready}, 32'd0);
                if (sb.size() == 0) begin
                    check("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    cur = sb.pop_front();
                    check({cur.name, "_result"}, result, cur.res);
                    check({cur.name, "_latency"}, 32'(cyc - cur.start_cyc + 1), 32'(cur.lat));
                    check({cur.name, "_busy_run"}, 32'(run), 32'(cur.busy_run));
                end
                last_res   = result;
                last_valid = 1'b1;
                run        = 0;
            end else begin
                if (last_valid) check("result_hold", result, last_res);
                if (busy) run++;
                else      run = 0;
            end
            prev_ready = ready;
        end
    end

    task automatic push(input string name, input logic [31:0] res, input int scyc, input bit special);
        exp_t e;
        e.name      = name;
        e.res       = res;
        e.start_cyc = scyc;
        e.lat       = special ? 1 : 27;
        e.busy_run  = special ? 0 : 26;
        sb.push_back(e);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic issue(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input bit special);
        @(negedge clk);
        number1 = a;
        number2 = b;
        start   = 1'b1;
        push(name, res, cyc + 1, special);
        @(negedge clk);
        start = 1'b0;
        wait_drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_ready", {31'd0, ready}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_result", result, 32'd0);
        rst = 1'b0;

        issue("six_by_two",    32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0);
        issue("one_by_three",  32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 1'b0);
        issue("neg_by_zero",   32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 1'b1);
        issue("overflow",      32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 1'b0);
        issue("underflow",     32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 1'b0);
        issue("nan_operand",   32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 1'b1);
        issue("zero_by_zero",  32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b1);
        issue("inf_by_inf",    32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 1'b1);
        issue("inf_by_two",    32'h7F80_0000, 32'h4000_0000, 32'h7F80_0000, 1'b1);
        issue("inf_by_zero",   32'h7F80_0000, 32'h0000_0000, 32'h7F80_0000, 1'b1);
        issue("zero_by_neg",   32'h0000_0000, 32'hC000_0000, 32'h8000_0000, 1'b1);
        issue("two_by_neginf", 32'h4000_0000, 32'hFF80_0000, 32'h8000_0000, 1'b1);
        issue("denorm_by_one", 32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 1'b1);
        issue("neg_six_by_two",32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, 1'b0);
        issue("one_by_one",    32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0);

        // Start pulses mid-operation with different operands must be ignored.
        @(negedge clk);
        number1 = 32'h40C0_0000;
        number2 = 32'h4000_0000;
        start   = 1'b1;
        push("busy_start_ignored", 32'h4040_0000, cyc + 1, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        number1 = 32'h3F80_0000;
        number2 = 32'h4040_0000;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain();

        // Start held high: accepted in IDLE, ignored in DONE, accepted again next IDLE.
        @(negedge clk);
        number1 = 32'hBF80_0000;
        number2 = 32'h0000_0000;
        start   = 1'b1;
        push("held_start_first",  32'hFF80_0000, cyc + 1, 1'b1);
        push("held_start_second", 32'hFF80_0000, cyc + 3, 1'b1);
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_drain();

        // Reset during the divide loop aborts without a ready pulse.
        @(negedge clk);
        number1 = 32'h3F80_0000;
        number2 = 32'h4040_0000;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ready", {31'd0, ready}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        number1 = 32'h3F80_0000;
        number2 = 32'h3F80_0000;
        start   = 1'b1;
        push("after_abort", 32'h3F80_0000, cyc + 1, 1'b0);
        @(negedge clk);
        start = 1'b0;
        wait_drain();

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ieee_divider.md
IEEE_DIVIDER -- requirements
Module: ieee_divider

Interface
REQ-001 The block SHALL have these ports: clk, input, 1, rising-edge clock for all state.
REQ-002 The block SHALL have these ports: rst, input, 1, synchronous active-high reset.
REQ-003 The block SHALL have these ports: number1, input, 32, IEEE-754 single dividend; sampled only with start.
REQ-004 The block SHALL have these ports: number2, input, 32, IEEE-754 single divisor; sampled only with start.
REQ-005 The block SHALL have these ports: start, input, 1, request; accepted only in IDLE.
REQ-006 The block SHALL have these ports: result, output, 32, quotient; held stable from ready until the next accepted start.
REQ-007 The block SHALL have these ports: ready, output, 1, one-cycle pulse marking result valid.
REQ-008 The block SHALL have these ports: busy, output, 1, high in every state except IDLE.
REQ-009 The block SHALL have these parameters: QBITS, default 25, quotient bits produced (24 mantissa plus 1 normalisation bit).

Function
REQ-010 The state machine SHALL have states IDLE, DIV, NORM and DONE.
REQ-011 Transitions SHALL be IDLE->DIV on start with normal operands, IDLE->DONE on start with a special case, DIV->NORM after QBITS iterations, NORM->DONE, and DONE->IDLE.
REQ-012 On accepting start, the block SHALL latch the sign, exponents and mantissas {1,frac}.
REQ-013 Sign SHALL be number1[31] XOR number2[31] for every case, including specials.
REQ-014 DIV SHALL run one restoring radix-2 step per cycle, with a 5-bit iteration counter counting 0..QBITS-1.
REQ-015 Each DIV step SHALL perform: remainder minus divisor; if non-negative, keep the difference and shift in 1; else keep the remainder and shift in 0.
REQ-016 The exponent SHALL be computed in 10-bit signed arithmetic as e = E1 - E2 + 127.
REQ-017 In NORM, if quotient MSB = 0, the block SHALL shift the quotient left by 1 and set e = e - 1.
REQ-018 Mantissa rounding SHALL be truncation (round toward zero); the remainder SHALL be discarded.
REQ-019 If e >= 255 after NORM, result SHALL be signed infinity.
REQ-020 If e <= 0 after NORM, result SHALL be signed zero.
REQ-021 Denormal inputs (E = 0) SHALL be treated as zero.
REQ-022 Special-case priority SHALL be:
- any NaN, 0/0 or inf/inf -> 32'h7FC00000;
- x/0 or inf/x -> signed infinity;
- 0/x or x/inf -> signed zero.
REQ-023 Normal latency SHALL be: ready high in the cycle following the 27th rising edge counted from the edge that sampled start.
REQ-024 Special-case latency SHALL be: ready high in the cycle following the 1st rising edge counted from the edge that sampled start.
REQ-025 ready SHALL be high only in DONE.
REQ-026 start asserted while busy SHALL be ignored, with no effect on the operation in progress.
REQ-027 start held high in DONE SHALL NOT be accepted; it is accepted on the next IDLE cycle.
REQ-028 result SHALL update only on the transition into DONE.

Reset
REQ-029 While rst is high at a clock edge, the block SHALL set state = IDLE, result = 0, ready = 0, busy = 0, and clear the counter, quotient and remainder.
REQ-030 rst asserted mid-operation SHALL abort the operation with no ready pulse.
REQ-031 The first start SHALL be accepted one cycle after rst falls.
REQ-032 rst SHALL dominate start when both are high.

Structure
REQ-033 A shared package ieee_fp_pkg SHALL hold:
- the state enum;
- BIAS = 127;
- QNAN = 32'h7FC00000;
- EXP_W = 8;
- FRAC_W = 23.
REQ-034 The combinational restoring step SHALL be a single sub-module, restoring_div_step: inputs remainder and divisor, outputs new remainder and quotient bit.
REQ-035 All sequential logic SHALL be in one always_ff block, and next-state logic in always_comb.

Verification
REQ-036 Start with 0x40C00000 / 0x40000000 -> result 0x40400000 (3.0); ready after 27 cycles; busy high for 26 cycles before it.
REQ-037 Start with 0x3F800000 / 0x40400000 -> result 0x3EAAAAAA (truncated 1/3); NORM shift applied.
REQ-038 Start with 0xBF800000 / 0x00000000 -> result 0xFF800000; ready after 1 cycle.
REQ-039 Start with 0x7F000000 / 0x3E800000 -> result 0x7F800000 (overflow); start with 0x00800000 / 0x7F000000 -> result 0x00000000 (underflow).
REQ-040 Start pulsed at cycles 5 and 10 of an operation -> ignored; result unchanged and only one ready pulse.
REQ-041 rst at DIV iteration 12 -> no ready and all outputs zero; a new start of 0x3F800000 / 0x3F800000 -> result 0x3F800000.
